// File: rtl/main_memory_ctrl.sv
// Single-port word memory behind a valid/ready request/response handshake with fixed access latency.
// Optional macro MAIN_MEMORY_BOUNDS_CHECK_EN flags and suppresses accesses with req_addr >= DEPTH.
module main_memory_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 8192,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [IDX_W-1:0]    idx;
  logic                out_of_range;
  logic                accept;
  logic                access;
  logic                do_write;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] new_word,
                                                    input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  assign idx = addr_q[IDX_W-1:0];

`ifdef MAIN_MEMORY_BOUNDS_CHECK_EN
  // Any bit above the index field means the address lies beyond the array.
  assign out_of_range = (addr_q >> IDX_W) != '0;
`else
  assign out_of_range = 1'b0;
  logic unused_addr;
  assign unused_addr = ^addr_q;
`endif

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign access    = (state == WAIT) && (cnt == 4'd1);
  assign do_write  = access && write_q && !out_of_range && !reset;

  // Request capture: data registers carry no reset, they are only meaningful after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  // Array: survives reset; a write aborted by reset never reaches here.
  always_ff @(posedge clk) begin
    if (do_write) mem[idx] <= merge_bytes(mem[idx], wdata_q, be_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state <= WAIT;
            cnt   <= 4'(LATENCY);
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= (write_q || out_of_range) ? '0 : mem[idx];
            resp_err   <= out_of_range;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Randomized bench for main_memory_ctrl with a cycle-count reference model and directed literal cases.
module tb_main_memory_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 8192;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_be = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;

  int checks = 0;
  int errors = 0;

  main_memory_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

`ifdef MAIN_MEMORY_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  // Reference model: a transaction accepted at cycle t is answered at t+LAT and
  // retired at the first later edge with resp_ready high.
  logic [31:0] mmem [int];
  bit          busy = 0, in_resp = 0, known = 1;
  int          age = 0;
  logic        p_w;
  logic [31:0] p_addr, p_data;
  logic [3:0]  p_be;
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;

  initial begin
    logic s_reset, s_valid, s_write, s_rready, chk;
    logic [31:0] s_addr, s_data, word;
    logic [3:0] s_be;
    int wi;
    bit oor;
    forever begin
      @(posedge clk);
      s_reset = reset; s_valid = req_valid; s_write = req_write; s_rready = resp_ready;
      s_addr = req_addr; s_data = req_wdata; s_be = req_be;
      #1;
      chk = 1'b0;
      if (s_reset) begin
        busy = 0; in_resp = 0; exp_rdata = '0; exp_err = 1'b0; known = 1; chk = 1'b1;
      end else if (!busy) begin
        if (s_valid) begin
          busy = 1; age = 0; p_w = s_write; p_addr = s_addr; p_data = s_data; p_be = s_be;
        end
      end else if (!in_resp) begin
        age++;
        if (age == LAT) begin
          wi = int'(p_addr % DEPTH);
          oor = BC && (p_addr >= DEPTH);
          in_resp = 1; exp_err = oor; known = 1;
          if (p_w) begin
            exp_rdata = '0;
            if (!oor && (mmem.exists(wi) || p_be == 4'hF)) begin
              word = mmem.exists(wi) ? mmem[wi] : '0;
              for (int b = 0; b < 4; b++) if (p_be[b]) word[8*b +: 8] = p_data[8*b +: 8];
              mmem[wi] = word;
            end else if (!oor && p_be != 4'h0) begin
              mmem.delete(wi);
            end
          end else if (oor) begin
            exp_rdata = '0;
          end else if (mmem.exists(wi)) begin
            exp_rdata = mmem[wi];
          end else begin
            known = 0;
          end
        end
      end else if (s_rready) begin
        busy = 0; in_resp = 0;
      end
      if (in_resp) chk = 1'b1;
      check("req_ready", 32'(req_ready), 32'(!busy && !reset));
      check("resp_valid", 32'(resp_valid), 32'(in_resp));
      if (chk && known) begin
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_err", 32'(resp_err), 32'(exp_err));
      end
    end
  end

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input int hold, input logic pulse,
                     output logic [31:0] rd, output logic err);
    int n;
    int lat;
    rd = '0; err = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    resp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_write = 1'($urandom);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!resp_valid && lat < 50);
    check("latency", 32'(lat), 32'(LAT));
    rd = resp_rdata; err = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      req_valid = pulse && (i == 0);
    end
    @(negedge clk);
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] rd, a, d;
    logic        err;
    int          hold;

    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    check("reset_resp_err", 32'(resp_err), 32'd0);

    for (int i = 0; i < 32; i++) txn(1'b1, 32'(i), $urandom, 4'hF, 0, 1'b0, rd, err);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, rd, err);
    check("wr10_rdata", rd, 32'h0);
    check("wr10_err", 32'(err), 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, err);
    check("rd10_rdata", rd, 32'hDEADBEEF);
    check("rd10_err", 32'(err), 32'd0);

    txn(1'b1, 32'd5, 32'h11223344, 4'hF, 0, 1'b0, rd, err);
    txn(1'b1, 32'd5, 32'hAABBCCDD, 4'h5, 0, 1'b0, rd, err);
    txn(1'b0, 32'd5, 32'h0, 4'h0, 0, 1'b0, rd, err);
    check("rd5_merge", rd, 32'h11BB33DD);
    txn(1'b1, 32'd5, 32'hFFFFFFFF, 4'h0, 0, 1'b0, rd, err);
    txn(1'b0, 32'd5, 32'h0, 4'h0, 4, 1'b1, rd, err);
    check("rd5_be0_hold", rd, 32'h11BB33DD);

    // Abort a write by resetting one cycle after its accept.
    txn(1'b1, 32'd7, 32'h12345678, 4'hF, 0, 1'b0, rd, err);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd7; req_wdata = 32'h55; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    txn(1'b0, 32'd7, 32'h0, 4'h0, 0, 1'b0, rd, err);
    check("rd7_after_abort", rd, 32'h12345678);

    txn(1'b1, 32'd0, 32'hCAFEF00D, 4'hF, 0, 1'b0, rd, err);
    txn(1'b1, 32'd8192, 32'h0BADC0DE, 4'hF, 0, 1'b0, rd, err);
    check("wr8192_err", 32'(err), 32'(BC));
    txn(1'b0, 32'd0, 32'h0, 4'h0, 0, 1'b0, rd, err);
    check("rd0_after_8192", rd, BC ? 32'hCAFEF00D : 32'h0BADC0DE);

    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'(DEPTH + $urandom_range(0, 31)) : 32'($urandom_range(0, 31));
      d = $urandom;
      hold = $urandom_range(0, 3);
      txn(1'($urandom), a, d, 4'($urandom), hold, 1'($urandom), rd, err);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
